// File: rtl/usb_tx_ram_streamer.sv
// USB TX RAM streamer: reads 32-bit words from the TX RAM and
// emits them little-endian as a valid/ready byte stream with a last marker.
module usb_tx_ram_streamer #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 1025,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    input  logic [31:0]       ram_readdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last
);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, FLUSH} state_t;

    localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(DEPTH * 4);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    state_t state, state_nx;

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] rd_left;
    logic [LEN_W-1:0]  rem;
    logic [1:0]        k;
    logic [31:0]       cur;
    logic [31:0]       pre;
    logic              pre_valid;
    logic              rd_valid;

    logic [LEN_W-1:0]  len_sat;
    logic [LEN_W-1:0]  words;
    logic              accept;
    logic              hs;
    logic              issue;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADR) ? '0 : a + ADDR_W'(1);
    endfunction

    always_comb begin
        len_sat = (length > MAX_LEN) ? MAX_LEN : length;
        words   = (len_sat + LEN_W'(3)) >> 2;
    end

    assign accept = (state == IDLE) && start && !abort;
    assign hs     = tx_valid && tx_ready;
    // One word in flight or parked at most; never read past the final word.
    assign issue  = (state == STREAM) && !abort && !pre_valid &&
                    !ram_chipselect && !rd_valid && (rd_left != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (accept) state_nx = (len_sat == '0) ? FLUSH : FETCH;
            FETCH:  if (rd_valid) state_nx = STREAM;
            STREAM: if (hs && rem == LEN_W'(1)) state_nx = FLUSH;
            FLUSH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE) state_nx = IDLE;
    end

    always_comb begin
        busy     = (state == FETCH) || (state == STREAM);
        done     = (state == FLUSH);
        tx_valid = (state == STREAM);
        tx_last  = (state == STREAM) && (rem == LEN_W'(1));
        tx_data  = '0;
        if (state == STREAM) tx_data = cur[{k, 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_address    <= '0;
            ram_chipselect <= 1'b0;
            rd_valid       <= 1'b0;
            ptr            <= '0;
            rd_left        <= '0;
            rem            <= '0;
            k              <= '0;
            cur            <= '0;
            pre            <= '0;
            pre_valid      <= 1'b0;
        end else begin
            rd_valid       <= ram_chipselect;
            ram_chipselect <= 1'b0;
            if (accept && len_sat != '0) begin
                ram_address    <= base_addr;
                ram_chipselect <= 1'b1;
                ptr            <= wrap_inc(base_addr);
                rd_left        <= ADDR_W'(words - LEN_W'(1));
                rem            <= len_sat;
                k              <= '0;
                pre_valid      <= 1'b0;
            end else if (issue) begin
                ram_address    <= ptr;
                ram_chipselect <= 1'b1;
                ptr            <= wrap_inc(ptr);
                rd_left        <= rd_left - ADDR_W'(1);
            end
            if (state == FETCH && rd_valid) cur <= ram_readdata;
            if (hs) begin
                rem <= rem - LEN_W'(1);
                k   <= k + 2'd1;
                if (k == 2'd3) begin
                    cur       <= pre;
                    pre_valid <= 1'b0;
                end
            end
            if (state == STREAM && rd_valid) begin
                pre       <= ram_readdata;
                pre_valid <= 1'b1;
            end
            if (abort || state == FLUSH) pre_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_tx_ram_streamer.sv
// Bench for usb_tx_ram_streamer: random RAM contents and transfers
// compared against a byte-queue model derived from base/length.
module tb_usb_tx_ram_streamer;

    localparam int DEPTH = 1025;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [10:0] base_addr;
    logic [12:0] length;
    logic        abort;
    logic        busy;
    logic        done;
    logic [10:0] ram_address;
    logic        ram_chipselect;
    logic [31:0] ram_readdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;

    logic [31:0] mem [0:DEPTH-1];
    logic [10:0] addr_q = '0;

    int checks = 0;
    int errors = 0;

    usb_tx_ram_streamer dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .base_addr(base_addr),
        .length(length),
        .abort(abort),
        .busy(busy),
        .done(done),
        .ram_address(ram_address),
        .ram_chipselect(ram_chipselect),
        .ram_readdata(ram_readdata),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_last(tx_last)
    );

    always #5 clk = ~clk;

    // RAM with registered address and unregistered output
    always @(posedge clk) if (ram_chipselect) addr_q <= ram_address;
    assign ram_readdata = (int'(addr_q) < DEPTH) ? mem[addr_q] : 32'hxxxxxxxx;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, tx_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cs"}, ram_chipselect, 0);
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready
    task automatic run_xfer(input int base, input int len, input int mode,
                            input int abort_after, input bit inject);
        logic [7:0] exp_b[$];
        int exp_a[$];
        int reads[$];
        int n, nw, idx, last_k, cnt;
        logic [7:0] held;
        bit hold, fin, seen_v, rdy;
        int a;
        n = (len > 4100) ? 4100 : len;
        nw = (n + 3) / 4;
        for (int i = 0; i < n; i++) begin
            a = (base + i / 4) % DEPTH;
            exp_b.push_back(mem[a][8*(i%4) +: 8]);
        end
        for (int w = 0; w < nw; w++) exp_a.push_back((base + w) % DEPTH);
        idx = 0; last_k = 0; cnt = 0; hold = 0; fin = 0; seen_v = 0;
        @(negedge clk);
        start = 1; base_addr = 11'(base); length = 13'(len);
        for (int k = 1; k <= 20000 && !fin; k++) begin
            @(negedge clk);
            start = 0;
            if (ram_chipselect) reads.push_back(int'(ram_address));
            if (k == 1) check("busy_rise", busy, n != 0);
            case (mode)
                0: rdy = 1;
                1: rdy = (cnt % 3 == 0);
                default: rdy = $urandom_range(0, 1) != 0;
            endcase
            cnt++;
            tx_ready = rdy;
            if (hold) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, held);
            end
            hold = 0;
            if (tx_valid) begin
                if (!seen_v) begin
                    check("first_valid_cycle", k, 3);
                    seen_v = 1;
                end
                if (rdy) begin
                    if (idx >= n) check("extra_byte", idx, n);
                    else begin
                        check("byte", tx_data, exp_b[idx]);
                        check("last", tx_last, idx == n - 1);
                    end
                    if (mode == 0) check("no_bubble", k, 3 + idx);
                    idx++;
                    last_k = k;
                    if (abort_after != 0 && idx == abort_after) fin = 1;
                end else begin
                    hold = 1;
                    held = tx_data;
                end
            end
            if (done) begin
                check("done_bytes", idx, n);
                check("busy_at_done", busy, 0);
                if (n == 0) check("zero_len_done_cycle", k, 1);
                else check("done_latency", k, last_k + 1);
                fin = 1;
            end
            if (inject && k == 5 && busy) begin
                start = 1;
                base_addr = 11'($urandom_range(0, 1024));
                length = 13'($urandom_range(0, 50));
            end
        end
        start = 0;
        if (!fin) check("timeout", 0, 1);
        if (abort_after != 0) begin
            @(negedge clk);
            abort = 1; tx_ready = 0;
            @(negedge clk);
            abort = 0;
            check_quiet("abort");
            cnt = 0;
            repeat (4) begin
                @(negedge clk);
                if (done || tx_valid || busy) cnt++;
            end
            check("abort_quiet", cnt, 0);
        end else begin
            @(negedge clk);
            check_quiet("post_done");
            check("read_count", reads.size(), nw);
            for (int i = 0; i < reads.size() && i < nw; i++)
                check("read_addr", reads[i], exp_a[i]);
        end
    endtask

    initial begin
        reset_n = 0; start = 0; abort = 0; tx_ready = 0;
        base_addr = '0; length = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check("reset_addr", ram_address, 0);
        check("reset_last", tx_last, 0);
        check("reset_data", tx_data, 0);
        reset_n = 1;
        @(negedge clk);

        mem[0] = 32'h44332211; mem[1] = 32'h88776655;
        run_xfer(0, 8, 0, 0, 0);
        mem[1024] = 32'hDDCCBBAA; mem[0] = 32'h0000FFEE;
        run_xfer(1024, 6, 0, 0, 0);
        run_xfer($urandom_range(0, 1024), 5, 1, 0, 1);
        run_xfer(17, 0, 0, 0, 0);
        run_xfer($urandom_range(0, 1024), 100, 0, 10, 0);
        run_xfer($urandom_range(0, 1024), 4, 0, 0, 0);

        // abort coinciding with start in idle: start must be ignored
        @(negedge clk);
        start = 1; abort = 1; base_addr = 11'd5; length = 13'd8;
        @(negedge clk);
        start = 0; abort = 0;
        check_quiet("abort_start");

        for (int t = 0; t < 8; t++)
            run_xfer($urandom_range(0, 1024), $urandom_range(1, 300),
                     2, 0, 1);
        for (int t = 0; t < 4; t++)
            run_xfer($urandom_range(0, 1024), $urandom_range(1, 12),
                     t % 3, 0, 0);
        run_xfer($urandom_range(0, 1024), 5000, 0, 0, 0);

        // reset in the middle of streaming
        @(negedge clk);
        start = 1; base_addr = 11'd7; length = 13'd40; tx_ready = 1;
        @(negedge clk);
        start = 0;
        repeat (6) @(negedge clk);
        check("pre_reset_valid", tx_valid, 1);
        reset_n = 0;
        #1;
        check_quiet("midreset");
        check("midreset_addr", ram_address, 0);
        check("midreset_data", tx_data, 0);
        check("midreset_last", tx_last, 0);
        @(negedge clk);
        reset_n = 1;
        run_xfer($urandom_range(0, 1024), 23, 2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
